// File: rtl/spi_apb_pkg.sv
// Shared definitions for the SPI register APB master: register map,
// legal address ceiling, arbiter FSM states and the address legality check.
package spi_apb_pkg;

  localparam logic [31:0] SPI_CR1     = 32'h00;
  localparam logic [31:0] SPI_CR2     = 32'h04;
  localparam logic [31:0] SPI_SR      = 32'h08;
  localparam logic [31:0] SPI_DR_TX   = 32'h0C;
  localparam logic [31:0] SPI_CRCPR   = 32'h10;
  localparam logic [31:0] SPI_RXCRCR  = 32'h14;
  localparam logic [31:0] SPI_TXCRCR  = 32'h18;
  localparam logic [31:0] SPI_I2SCFGR = 32'h1C;
  localparam logic [31:0] SPI_I2SPR   = 32'h20;
  localparam logic [31:0] SPI_DR_RX   = 32'h24;

  localparam logic [31:0] SPI_MAX_ADDR = SPI_DR_RX;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RESP
  } arb_state_t;

  // Word aligned and inside the register window.
  function automatic logic addr_is_legal(input logic [31:0] addr,
                                         input logic [31:0] max_addr);
    return (addr[1:0] == 2'b00) && (addr <= max_addr);
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that was not granted last wins. History moves only on advance.
module apb_rr_arb2 (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;  // index of the requester granted most recently

  // Grant selection from current requests and history.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // History register; reset value makes requester 0 win the first tie.
  always_ff @(posedge PCLK) begin
    if (PRESET)
      last_q <= 1'b1;
    else if (advance && (grant != 2'b00))
      last_q <= grant[1];
  end

endmodule

// File: rtl/apb_spi_req_arbiter.sv
// Two-requester APB master in front of the SPI register slave.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request; grant and latch the winner
// SETUP   | APB setup phase, PSEL=1 PENABLE=0
// ACCESS  | APB access phase, waiting for PREADY or timeout
// CAPTURE | bus released, slave's registered PRDATA sampled
// RESP    | one-cycle response pulse on the owner's port
module apb_spi_req_arbiter
  import spi_apb_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] MAX_ADDR = SPI_MAX_ADDR
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR
);

  localparam int          TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  arb_state_t    state_q, state_d;
  logic [1:0]    grant;
  logic          take;
  logic          own_q, own_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [15:0]   rdata_d;
  logic          psel_d, penable_d;
  logic [TW-1:0] tmr_q;
  logic          sel_write, sel_legal;
  logic [31:0]   sel_addr;
  logic [15:0]   sel_wdata;
  logic          unused_prdata_hi;

  assign unused_prdata_hi = ^PRDATA[31:16];

  apb_rr_arb2 u_arb (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .valid   ({req1_valid, req0_valid}),
    .advance (take),
    .grant   (grant)
  );

  assign take       = (state_q == ST_IDLE) && (grant != 2'b00);
  assign req0_ready = (state_q == ST_IDLE) && grant[0];
  assign req1_ready = (state_q == ST_IDLE) && grant[1];

  assign sel_write = grant[1] ? req1_write : req0_write;
  assign sel_addr  = grant[1] ? req1_addr  : req0_addr;
  assign sel_wdata = grant[1] ? req1_wdata : req0_wdata;
  assign sel_legal = addr_is_legal(sel_addr, MAX_ADDR);

  // Next state, response data/error and registered-output intents.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = 16'h0000;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = sel_legal ? ST_SETUP : ST_RESP;
          err_d   = ~sel_legal;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          err_d   = PSLVERR;
          state_d = wr_q ? ST_RESP : ST_CAPTURE;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_RESP;
        rdata_d = err_q ? 16'h0000 : PRDATA[15:0];
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    own_d     = take ? grant[1] : own_q;
    wr_d      = take ? sel_write : wr_q;
    psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = (state_d == ST_ACCESS);
  end

  // State, transaction context and registered APB / response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      own_q      <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= 32'h0;
      PWDATA     <= 32'h0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= 16'h0;
      rsp1_rdata <= 16'h0;
      rsp0_err   <= 1'b0;
      rsp1_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      PSEL       <= psel_d;
      PENABLE    <= penable_d;
      PWRITE     <= psel_d & wr_d;
      if (take && sel_legal) begin
        PADDR  <= sel_addr;
        PWDATA <= {16'h0, sel_wdata};
      end
      rsp0_valid <= (state_d == ST_RESP) && !own_d;
      rsp1_valid <= (state_d == ST_RESP) &&  own_d;
      rsp0_rdata <= ((state_d == ST_RESP) && !own_d) ? rdata_d : 16'h0;
      rsp1_rdata <= ((state_d == ST_RESP) &&  own_d) ? rdata_d : 16'h0;
      rsp0_err   <= (state_d == ST_RESP) && !own_d && err_d;
      rsp1_err   <= (state_d == ST_RESP) &&  own_d && err_d;
    end
  end

  // PREADY timeout: down-counter loaded during SETUP, abort at zero.
  always_ff @(posedge PCLK) begin
    if (PRESET)
      tmr_q <= '0;
    else if (state_q == ST_SETUP)
      tmr_q <= TMR_LOAD;
    else if ((state_q == ST_ACCESS) && !PREADY && (tmr_q != '0))
      tmr_q <= tmr_q - TW'(1);
  end

endmodule

// File: tb/tb_apb_spi_req_arbiter.sv
// Bench for apb_spi_req_arbiter: transaction-level timeline model plus a
// small APB slave with registered PRDATA.
module tb_apb_spi_req_arbiter;

  localparam int TO   = 16;
  localparam int NCYC = 1024;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req1_addr;
  logic [15:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [15:0] rsp0_rdata, rsp1_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = 32'hBEEF_0000;

  bit stall = 1'b0;
  bit force_err = 1'b0;

  apb_spi_req_arbiter #(.TIMEOUT(TO), .MAX_ADDR(32'h24)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave: zero wait (PREADY follows PSEL) unless stalled; PSLVERR high when idle.
  logic [15:0] s_mem [0:15] = '{default: 16'h0};
  assign PREADY  = stall ? 1'b0 : PSEL;
  assign PSLVERR = !PSEL | force_err;
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY) begin
      if (PWRITE) begin
        if (!force_err) s_mem[PADDR[5:2]] <= PWDATA[15:0];
      end else begin
        PRDATA <= {16'hBEEF, s_mem[PADDR[5:2]]};
      end
    end
  end

  typedef struct packed {
    logic            psel;
    logic            pen;
    logic            pwrite;
    logic [31:0]     paddr;
    logic [15:0]     pwdata;
    logic [1:0]      rdy;
    logic [1:0]      rv;
    logic [1:0]      er;
    logic [1:0][15:0] rd;
  } exp_t;

  exp_t        e [0:NCYC-1];
  exp_t        x;
  logic [15:0] m_mem [0:15] = '{default: 16'h0};
  int          m_last = 1;
  int          nvec = 0;
  int          nmis = 0;
  bit          chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Timeline model: given grant cycle t, lay out the expected bus and response cycles.
  task automatic sched(input int w, input int t, input bit wr, input logic [31:0] a,
                       input logic [15:0] d, output int rc);
    bit          legal;
    bit          er;
    logic [15:0] rd;
    int          alen;
    legal = (a[1:0] == 2'b00) && (a <= 32'h24);
    e[t].rdy[w] = 1'b1;
    rd = 16'h0;
    if (!legal) begin
      rc = t + 1;
      er = 1'b1;
    end else begin
      alen = stall ? TO : 1;
      for (int c = t + 1; c <= t + 1 + alen; c++) begin
        e[c].psel   = 1'b1;
        e[c].pen    = (c >= t + 2);
        e[c].pwrite = wr;
        e[c].paddr  = a;
        e[c].pwdata = d;
      end
      if (stall) begin
        rc = t + 2 + alen;
        er = 1'b1;
      end else if (wr) begin
        rc = t + 3;
        er = force_err;
        if (!force_err) m_mem[a[5:2]] = d;
      end else begin
        rc = t + 4;
        er = force_err;
        rd = force_err ? 16'h0 : m_mem[a[5:2]];
      end
    end
    e[rc].rv[w] = 1'b1;
    e[rc].er[w] = er;
    e[rc].rd[w] = rd;
    m_last = w;
  endtask

  // Every-cycle comparison against the model timeline.
  always @(negedge PCLK) begin
    if (chk_en && cyc < NCYC) begin
      x = e[cyc];
      cmp("psel",    32'(PSEL),       32'(x.psel));
      cmp("penable", 32'(PENABLE),    32'(x.pen));
      cmp("ready0",  32'(req0_ready), 32'(x.rdy[0]));
      cmp("ready1",  32'(req1_ready), 32'(x.rdy[1]));
      cmp("rsp0_v",  32'(rsp0_valid), 32'(x.rv[0]));
      cmp("rsp1_v",  32'(rsp1_valid), 32'(x.rv[1]));
      if (x.psel) begin
        cmp("paddr",  PADDR,         x.paddr);
        cmp("pwrite", 32'(PWRITE),   32'(x.pwrite));
        if (x.pwrite) cmp("pwdata", PWDATA, {16'h0, x.pwdata});
      end
      if (x.rv[0]) begin
        cmp("rsp0_rdata", 32'(rsp0_rdata), 32'(x.rd[0]));
        cmp("rsp0_err",   32'(rsp0_err),   32'(x.er[0]));
      end
      if (x.rv[1]) begin
        cmp("rsp1_rdata", 32'(rsp1_rdata), 32'(x.rd[1]));
        cmp("rsp1_err",   32'(rsp1_err),   32'(x.er[1]));
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive(input int w, input bit v, input bit wr, input logic [31:0] a,
                       input logic [15:0] d);
    if (w == 0) begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic single(input int w, input bit wr, input logic [31:0] a, input logic [15:0] d,
                        output bit gv, output logic [15:0] grd, output bit ge);
    int rc;
    drive(w, 1'b1, wr, a, d);
    sched(w, cyc, wr, a, d, rc);
    tick();
    drive(w, 1'b0, 1'b0, 32'h0, 16'h0);
    while (cyc < rc) tick();
    @(negedge PCLK);
    gv  = (w == 0) ? rsp0_valid : rsp1_valid;
    grd = (w == 0) ? rsp0_rdata : rsp1_rdata;
    ge  = (w == 0) ? rsp0_err   : rsp1_err;
    tick();
  endtask

  task automatic tie(input bit wr0, input logic [31:0] a0, input logic [15:0] d0,
                     input bit wr1, input logic [31:0] a1, input logic [15:0] d1,
                     output logic [1:0] seen);
    int rc;
    int w;
    drive(0, 1'b1, wr0, a0, d0);
    drive(1, 1'b1, wr1, a1, d1);
    w = (m_last == 0) ? 1 : 0;
    if (w == 0) sched(0, cyc, wr0, a0, d0, rc);
    else        sched(1, cyc, wr1, a1, d1, rc);
    @(negedge PCLK);
    seen = {req1_ready, req0_ready};
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 16'h0);
    while (cyc <= rc) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          gv, ge;
    logic [15:0] grd;
    logic [1:0]  seen;
    int          rc, t;

    for (int i = 0; i < NCYC; i++) e[i] = '0;
    PRESET = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 16'h0);
    repeat (3) tick();
    @(negedge PCLK);
    cmp("lit_rst_psel",    32'(PSEL),       32'd0);
    cmp("lit_rst_penable", 32'(PENABLE),    32'd0);
    cmp("lit_rst_pwrite",  32'(PWRITE),     32'd0);
    cmp("lit_rst_paddr",   PADDR,           32'd0);
    cmp("lit_rst_pwdata",  PWDATA,          32'd0);
    cmp("lit_rst_rsp",     32'({rsp1_valid, rsp0_valid, rsp1_err, rsp0_err}), 32'd0);
    cmp("lit_rst_rdata",   32'({rsp1_rdata, rsp0_rdata}), 32'd0);
    tick();
    PRESET = 1'b0;
    chk_en = 1'b1;
    tick();

    single(0, 1'b1, 32'h00, 16'h0344, gv, grd, ge);
    cmp("lit_wr_rsp_valid", 32'(gv), 32'd1);
    cmp("lit_wr_rsp_err",   32'(ge), 32'd0);
    single(0, 1'b0, 32'h00, 16'h0, gv, grd, ge);
    cmp("lit_rd_rdata", 32'(grd), 32'h0344);
    single(1, 1'b1, 32'h24, 16'hA5A5, gv, grd, ge);
    single(0, 1'b0, 32'h24, 16'h0, gv, grd, ge);
    cmp("lit_rd_max_rdata", 32'(grd), 32'hA5A5);
    single(1, 1'b1, 32'h20, 16'h1234, gv, grd, ge);
    single(1, 1'b0, 32'h20, 16'h0, gv, grd, ge);

    tie(1'b1, 32'h10, 16'h00AB, 1'b0, 32'h00, 16'h0, seen);
    cmp("lit_tie1", 32'(seen), 32'b01);
    tie(1'b0, 32'h10, 16'h0, 1'b1, 32'h14, 16'h0055, seen);
    cmp("lit_tie2", 32'(seen), 32'b10);
    tie(1'b0, 32'h14, 16'h0, 1'b1, 32'h18, 16'h0F0F, seen);
    cmp("lit_tie3", 32'(seen), 32'b01);

    single(1, 1'b0, 32'h06, 16'h0, gv, grd, ge);
    cmp("lit_misaligned_err", 32'(ge), 32'd1);
    single(1, 1'b0, 32'h28, 16'h0, gv, grd, ge);
    cmp("lit_range_err", 32'(ge), 32'd1);

    stall = 1'b1;
    single(0, 1'b0, 32'h08, 16'h0, gv, grd, ge);
    stall = 1'b0;
    cmp("lit_timeout_err",   32'(ge),  32'd1);
    cmp("lit_timeout_rdata", 32'(grd), 32'd0);

    force_err = 1'b1;
    single(1, 1'b1, 32'h0C, 16'h7777, gv, grd, ge);
    cmp("lit_slverr_wr", 32'(ge), 32'd1);
    single(0, 1'b0, 32'h00, 16'h0, gv, grd, ge);
    cmp("lit_slverr_rd", 32'(ge), 32'd1);
    force_err = 1'b0;
    single(0, 1'b0, 32'h0C, 16'h0, gv, grd, ge);
    cmp("lit_idle_slverr_ignored", 32'(ge), 32'd0);

    // Reset while the read is in ACCESS: bus drops, response is lost.
    t = cyc;
    drive(0, 1'b1, 1'b0, 32'h00, 16'h0);
    sched(0, t, 1'b0, 32'h00, 16'h0, rc);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    PRESET = 1'b1;
    for (int c = t + 3; c < t + 12; c++) e[c] = '0;
    m_last = 1;
    tick();
    PRESET = 1'b0;
    @(negedge PCLK);
    cmp("lit_rst_mid_psel",    32'(PSEL),    32'd0);
    cmp("lit_rst_mid_penable", 32'(PENABLE), 32'd0);
    repeat (3) tick();
    tie(1'b0, 32'h00, 16'h0, 1'b0, 32'h04, 16'h0, seen);
    cmp("lit_tie_after_rst", 32'(seen), 32'b01);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
